switch_request_scheduler: RTL and testbench
===========================================

SWITCH_REQUEST_SCHEDULER -- requirements
Module: switch_request_scheduler

Interface
REQ-001: Parameter DATA_W, default 32, width of each data word.
REQ-002: Parameter CNT_W, default 16, width of the transfer counter.
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: in_valid  input  4  per-source word-valid, bit i = source i.
REQ-006: in_data  input  4 x DATA_W  unpacked array; in_data[i] is the word from source i.
REQ-007: in_ready  output  4  per-source ready; a word transfers on an edge where in_valid[i] and in_ready[i] are both 1.
REQ-008: R  output  4  one-hot request lines to the switch.
REQ-009: D  output  4 x DATA_W  unpacked array of data lines to the switch.
REQ-010: sw_ready  input  1  switch accepts the presented word this cycle.
REQ-011: busy  output  1  high while a request is presented on R.
REQ-012: tx_count  output  CNT_W  number of completed switch transfers.

Function
REQ-013: Each source SHALL own a one-entry holding buffer, buf_valid[i] plus buf_data[i].
REQ-014: in_ready[i] SHALL equal ~buf_valid[i], decoded only from registers.
REQ-015: On an accept edge for source i, SHALL set buf_valid[i] to 1 and capture in_data[i].
REQ-016: The controller SHALL have two states, IDLE and BUSY.
REQ-017: In IDLE with any buf_valid set, SHALL select one pending source by round-robin, starting the search at ptr and proceeding ptr, ptr+1, ... mod 4.
REQ-018: On the selection edge, SHALL register R to the one-hot code of the selected source g, D[g] to buf_data[g], every other D[j] to 0, busy to 1, and move to BUSY.
REQ-019: In IDLE with no buf_valid set, R SHALL be 0, every D[j] SHALL be 0, and busy SHALL be 0.
REQ-020: R SHALL never have more than one bit set; an output with 2 or more bits set is a design error.
REQ-021: In BUSY with sw_ready=0, R, D and busy SHALL hold their values unchanged; there is no timeout.
REQ-022: In BUSY with sw_ready=1, the completion edge SHALL:
  - clear buf_valid[g];
  - set ptr to (g+1) mod 4;
  - increment tx_count, wrapping from all-ones to 0;
  - clear R, every D[j] and busy;
  - return to IDLE.
REQ-023: After a completion, in_ready[g] SHALL rise in the following cycle; there is always a one-cycle bubble between consecutive grants, so peak throughput is one word per 2 cycles.
REQ-024: Minimum latency, in_valid accept edge to R asserted, SHALL be 1 edge: R goes high after the next edge following the accept.
REQ-025: Sources other than g SHALL keep accepting words while in BUSY, subject to their own in_ready.
REQ-026: sw_ready SHALL be ignored in IDLE.

Reset
REQ-027: While rst=1 on an edge, SHALL clear every buf_valid, set ptr=0, state=IDLE, R=0, every D[j]=0, busy=0 and tx_count=0; buf_data contents are don't-care.
REQ-028: Reset asserted in BUSY SHALL abort the pending transfer: the word is dropped, tx_count is not incremented, and no R bit survives past the reset edge.
REQ-029: in_valid SHALL be ignored on reset edges; in_ready SHALL read 4'b1111 in the first cycle after reset release.

Verification
REQ-030: Single source: in_valid=4'b0100, in_data[2]=32'hCCCC2222, sw_ready=1 -> R=4'b0100 and D[2]=32'hCCCC2222 one cycle after accept, with other D=0; R=0 and tx_count=1 one cycle later.
REQ-031: All four buffers full, ptr=0, sw_ready=1 -> grant order 0,1,2,3, with R = 0001, 0010, 0100, 1000 separated by R=0 bubbles; tx_count=4; R is never multi-hot.
REQ-032: Backpressure: grant source 1 with sw_ready=0 for 5 cycles, then 1 -> R=4'b0010 and D[1] held stable for all 5 cycles; completion occurs on the first edge with sw_ready=1.
REQ-033: Fairness: source 0 is refilled immediately after each grant while source 3 stays pending -> source 3 is granted no later than the second grant after it became pending.
REQ-034: Reset mid-BUSY: assert rst while R=4'b1000 -> R=0, in_ready=4'b1111 and tx_count unchanged at 0 after reset; the word is not re-sent.
REQ-035: Counter wrap: with CNT_W=4, perform 17 transfers -> tx_count reads 1.

Source files
------------

// File: rtl/switch_request_scheduler.sv
// rtl/switch_request_scheduler.sv - four-source round-robin request scheduler feeding a switch
//
// Purpose
//   Each of four sources owns a one-entry holding buffer. A two-state controller
//   picks one pending buffer round-robin, presents it to the switch on R/D and
//   holds it there until the switch takes it with sw_ready.
//
// Ports
//   clk       in   1          single clock, rising edge
//   rst       in   1          synchronous, active-high reset
//   in_valid  in   4          per-source word valid
//   in_data   in   4xDATA_W   per-source word
//   in_ready  out  4          per-source ready (buffer empty), register-decoded
//   R         out  4          one-hot request lines to the switch
//   D         out  4xDATA_W   data lines; only the granted lane is non-zero
//   sw_ready  in   1          switch accepts the presented word
//   busy      out  1          a request is presented on R
//   tx_count  out  CNT_W      completed switch transfers, wraps

module switch_request_scheduler #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        in_valid,
    input  logic [DATA_W-1:0] in_data [4],
    output logic [3:0]        in_ready,
    output logic [3:0]        R,
    output logic [DATA_W-1:0] D [4],
    input  logic              sw_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  tx_count
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          buf_valid_q, buf_valid_d;
    logic [DATA_W-1:0]   buf_data_q [4];
    logic [DATA_W-1:0]   buf_data_d [4];
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          grant_q, grant_d;
    logic [3:0]          r_q, r_d;
    logic [DATA_W-1:0]   d_q [4];
    logic [DATA_W-1:0]   d_d [4];
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    tx_count_q, tx_count_d;

    logic                sel_found;
    logic [1:0]          sel_idx;
    logic                grant_start;
    logic                complete;

    // Round-robin search over registered buffer state, starting at ptr.
    // A word accepted on this edge is therefore first eligible on the next edge.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!sel_found && buf_valid_q[ptr_q + 2'(k)]) begin
                sel_found = 1'b1;
                sel_idx   = ptr_q + 2'(k);
            end
        end
    end

    assign grant_start = (state_q == IDLE) && sel_found;
    assign complete    = (state_q == BUSY) && sw_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            buf_valid_q <= 4'b0000;
            ptr_q       <= 2'd0;
            grant_q     <= 2'd0;
            r_q         <= 4'b0000;
            busy_q      <= 1'b0;
            tx_count_q  <= '0;
            for (int j = 0; j < 4; j++) begin
                d_q[j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            r_q         <= r_d;
            busy_q      <= busy_d;
            tx_count_q  <= tx_count_d;
            d_q         <= d_d;
        end
    end

    // Buffer contents are qualified by buf_valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        buf_data_q <= buf_data_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_found) state_d = BUSY;
            BUSY:    if (sw_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        r_d         = r_q;
        d_d         = d_q;
        busy_d      = busy_q;
        tx_count_d  = tx_count_q;

        // Source side: an empty buffer takes whatever is offered. The granted
        // buffer is full throughout BUSY, so it can never be overwritten here.
        for (int i = 0; i < 4; i++) begin
            if (in_valid[i] && !buf_valid_q[i]) begin
                buf_valid_d[i] = 1'b1;
                buf_data_d[i]  = in_data[i];
            end
        end

        if (grant_start) begin
            grant_d = sel_idx;
            r_d     = 4'b0001 << sel_idx;
            busy_d  = 1'b1;
            for (int j = 0; j < 4; j++) begin
                d_d[j] = (2'(j) == sel_idx) ? buf_data_q[j] : '0;
            end
        end

        // Completion frees the buffer; in_ready for it rises after this edge,
        // and the IDLE cycle that follows is the inter-grant bubble.
        if (complete) begin
            buf_valid_d[grant_q] = 1'b0;
            ptr_d                = grant_q + 2'd1;
            tx_count_d           = tx_count_q + CNT_W'(1);
            r_d                  = 4'b0000;
            busy_d               = 1'b0;
            for (int j = 0; j < 4; j++) begin
                d_d[j] = '0;
            end
        end
    end

    assign in_ready = ~buf_valid_q;
    assign R        = r_q;
    assign D        = d_q;
    assign busy     = busy_q;
    assign tx_count = tx_count_q;

endmodule

// File: tb/tb_switch_request_scheduler.sv
// tb/tb_switch_request_scheduler.sv - directed self-checking bench for switch_request_scheduler

module tb_switch_request_scheduler;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    in_valid;
    logic [DW-1:0] in_data [4];
    logic [3:0]    in_ready;
    logic [3:0]    R;
    logic [DW-1:0] D [4];
    logic          sw_ready;
    logic          busy;
    logic [CW-1:0] tx_count;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    switch_request_scheduler #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .R        (R),
        .D        (D),
        .sw_ready (sw_ready),
        .busy     (busy),
        .tx_count (tx_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("r_onehot", 64'($countones(R) <= 1), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 4'b1111;
        sw_ready = 1'b0;
        for (int i = 0; i < 4; i++) in_data[i] = 32'hDEAD_0000 + 32'(i);

        // Reset, with in_valid held high on the reset edges
        step();
        step();
        rst      = 1'b0;
        in_valid = 4'b0000;
        check("rst_in_ready", 64'(in_ready), 64'hF);
        check("rst_r", 64'(R), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_tx", 64'(tx_count), 64'h0);
        check("rst_d0", 64'(D[0]), 64'h0);

        // Single source 2
        in_valid   = 4'b0100;
        in_data[2] = 32'hCCCC_2222;
        sw_ready   = 1'b1;
        step();
        in_valid = 4'b0000;
        check("single_in_ready", 64'(in_ready), 64'hB);
        check("single_r_accept", 64'(R), 64'h0);
        step();
        check("single_r", 64'(R), 64'h4);
        check("single_d2", 64'(D[2]), 64'hCCCC_2222);
        check("single_d0", 64'(D[0]), 64'h0);
        check("single_d1", 64'(D[1]), 64'h0);
        check("single_d3", 64'(D[3]), 64'h0);
        check("single_busy", 64'(busy), 64'h1);
        step();
        check("single_r_done", 64'(R), 64'h0);
        check("single_busy_done", 64'(busy), 64'h0);
        check("single_tx", 64'(tx_count), 64'h1);
        check("single_d2_clr", 64'(D[2]), 64'h0);
        check("single_ready_back", 64'(in_ready), 64'hF);

        // All four full with ptr = 0
        do_reset();
        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) in_data[i] = 32'h1000_0000 + 32'(i);
        step();
        in_valid = 4'b0000;
        check("all_full", 64'(in_ready), 64'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_r", 64'(R), 64'(4'b0001 << k));
            check("rr_d", 64'(D[k]), 64'(32'h1000_0000 + 32'(k)));
            check("rr_busy", 64'(busy), 64'h1);
            step();
            check("rr_bubble", 64'(R), 64'h0);
        end
        check("rr_tx", 64'(tx_count), 64'h4);

        // Backpressure on source 1 (ptr = 0)
        sw_ready   = 1'b0;
        in_valid   = 4'b0010;
        in_data[1] = 32'hB1B1_0001;
        step();
        in_valid = 4'b0000;
        step();
        check("bp_r_grant", 64'(R), 64'h2);
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_r_hold", 64'(R), 64'h2);
            check("bp_d1_hold", 64'(D[1]), 64'hB1B1_0001);
            check("bp_busy_hold", 64'(busy), 64'h1);
            check("bp_tx_hold", 64'(tx_count), 64'h4);
        end
        sw_ready = 1'b1;
        step();
        check("bp_r_done", 64'(R), 64'h0);
        check("bp_tx", 64'(tx_count), 64'h5);

        // Move ptr from 2 to 0 via a grant of source 3
        in_valid   = 4'b1000;
        in_data[3] = 32'hD3D3_0003;
        step();
        in_valid = 4'b0000;
        step();
        check("pre_r3", 64'(R), 64'h8);
        step();
        check("pre_tx", 64'(tx_count), 64'h6);

        // Fairness: 0 and 3 pending, 0 refilled right after its grant
        in_valid   = 4'b1001;
        in_data[0] = 32'hA0A0_0000;
        in_data[3] = 32'hA3A3_0003;
        step();
        in_valid = 4'b0000;
        step();
        check("fair_r0", 64'(R), 64'h1);
        check("fair_d0", 64'(D[0]), 64'hA0A0_0000);
        in_valid   = 4'b0001;
        in_data[0] = 32'hA0A0_0010;
        step();
        check("fair_done0", 64'(R), 64'h0);
        check("fair_tx7", 64'(tx_count), 64'h7);
        check("fair_ready", 64'(in_ready), 64'h7);
        step();
        in_valid = 4'b0000;
        check("fair_r3", 64'(R), 64'h8);
        check("fair_d3", 64'(D[3]), 64'hA3A3_0003);
        check("fair_refill", 64'(in_ready), 64'h6);
        step();
        check("fair_tx8", 64'(tx_count), 64'h8);
        step();
        check("fair_r0b", 64'(R), 64'h1);
        check("fair_d0b", 64'(D[0]), 64'hA0A0_0010);
        step();
        check("fair_tx9", 64'(tx_count), 64'h9);

        // Reset while BUSY with R = 1000
        do_reset();
        sw_ready   = 1'b0;
        in_valid   = 4'b1000;
        in_data[3] = 32'hEEEE_0003;
        step();
        in_valid = 4'b0000;
        step();
        check("abort_r_pre", 64'(R), 64'h8);
        step();
        check("abort_r_hold", 64'(R), 64'h8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_r", 64'(R), 64'h0);
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_in_ready", 64'(in_ready), 64'hF);
        check("abort_tx", 64'(tx_count), 64'h0);
        check("abort_d3", 64'(D[3]), 64'h0);
        sw_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("abort_no_resend", 64'(R), 64'h0);
            check("abort_tx_after", 64'(tx_count), 64'h0);
        end

        // Counter wrap with a 4-bit counter
        for (int t = 0; t < 17; t++) begin
            in_valid           = 4'(4'b0001 << (t % 4));
            in_data[t % 4]     = 32'h5000_0000 + 32'(t);
            step();
            in_valid = 4'b0000;
            step();
            check("wrap_r", 64'(R), 64'(4'b0001 << (t % 4)));
            check("wrap_d", 64'(D[t % 4]), 64'(32'h5000_0000 + 32'(t)));
            step();
            if (t == 15) check("wrap_tx16", 64'(tx_count), 64'h0);
        end
        check("wrap_tx17", 64'(tx_count), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
